signed_mult_arbiter: RTL and testbench



---
 rtl/signed_mult_pkg.sv | 19 +
 rtl/signed_mult_core.sv | 21 ++
 rtl/signed_mult_arbiter.sv | 153 +++++++++++++++
 tb/tb_signed_mult_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/signed_mult_pkg.sv
// Shared types and defaults for the signed multiplier arbiter.
package signed_mult_pkg;

    // Default operand width and grant-counter width
    localparam int W     = 4;
    localparam int CNT_W = 8;

    // Requester ids as carried on rsp_id
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/signed_mult_core.sv
// Purely combinational signed W x W -> 2W multiply. Operands are sign-extended
// to the full product width first so the result never truncates.
module signed_mult_core #(
    parameter int W = 4
) (
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    output logic signed [2*W-1:0] p
);

    logic signed [2*W-1:0] a_x;
    logic signed [2*W-1:0] b_x;

    // Sign-extend, then multiply at product width
    always_comb begin
        a_x = {{W{a[W-1]}}, a};
        b_x = {{W{b[W-1]}}, b};
        p   = a_x * b_x;
    end

endmodule

// File: rtl/signed_mult_arbiter.sv
// Two requesters share one signed multiplier. Round-robin grant in IDLE,
// operands latched on the grant cycle, product registered in MUL, and the
// tagged result held in RESP until the consumer takes it.
// Optional grant counters are built when SIGNED_MULT_ARB_STATS_EN is defined;
// otherwise grant_cnt0/grant_cnt1 are tied to zero.
module signed_mult_arbiter #(
    parameter int W     = signed_mult_pkg::W,
    parameter int CNT_W = signed_mult_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [W-1:0]       req0_a,
    input  logic [W-1:0]       req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [W-1:0]       req1_a,
    input  logic [W-1:0]       req1_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*W-1:0]     rsp_p,
    output logic               rsp_id,
    output logic [CNT_W-1:0]   grant_cnt0,
    output logic [CNT_W-1:0]   grant_cnt1
);

    import signed_mult_pkg::*;

    state_t            state_q, state_d;
    logic              last_id_q, last_id_d;
    logic [W-1:0]      op_a_q, op_a_d;
    logic [W-1:0]      op_b_q, op_b_d;
    logic              op_id_q, op_id_d;
    logic [2*W-1:0]    rsp_p_q, rsp_p_d;
    logic              rsp_id_q, rsp_id_d;

    logic              any_valid;
    logic              winner;
    logic signed [2*W-1:0] prod;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            winner = ~last_id_q;
        end else if (req1_valid) begin
            winner = REQ1;
        end else begin
            winner = REQ0;
        end
    end

    signed_mult_core #(.W(W)) u_core (
        .a (op_a_q),
        .b (op_b_q),
        .p (prod)
    );

    // Sequencer next-state, register loads and handshake outputs
    always_comb begin
        state_d    = state_q;
        last_id_d  = last_id_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_id_d    = op_id_q;
        rsp_p_d    = rsp_p_q;
        rsp_id_d   = rsp_id_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    req0_ready = (winner == REQ0);
                    req1_ready = (winner == REQ1);
                    op_a_d     = (winner == REQ1) ? req1_a : req0_a;
                    op_b_d     = (winner == REQ1) ? req1_b : req0_b;
                    op_id_d    = winner;
                    last_id_d  = winner;
                    state_d    = MUL;
                end
            end
            MUL: begin
                rsp_p_d  = prod;
                rsp_id_d = op_id_q;
                state_d  = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_id_q <= REQ1;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_id_q   <= REQ0;
            rsp_p_q   <= '0;
            rsp_id_q  <= REQ0;
        end else begin
            state_q   <= state_d;
            last_id_q <= last_id_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            op_id_q   <= op_id_d;
            rsp_p_q   <= rsp_p_d;
            rsp_id_q  <= rsp_id_d;
        end
    end

    assign rsp_p  = rsp_p_q;
    assign rsp_id = rsp_id_q;

`ifdef SIGNED_MULT_ARB_STATS_EN
    logic [CNT_W-1:0] grant_cnt0_q, grant_cnt0_d;
    logic [CNT_W-1:0] grant_cnt1_q, grant_cnt1_d;

    // Count accepted requests per requester; counters wrap naturally
    always_comb begin
        grant_cnt0_d = grant_cnt0_q + CNT_W'(req0_valid && req0_ready);
        grant_cnt1_d = grant_cnt1_q + CNT_W'(req1_valid && req1_ready);
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_signed_mult_arbiter.sv
// Self-checking bench for signed_mult_arbiter: directed cases pinned to
// hand-computed values, then randomized traffic checked every cycle against
// a transaction-level model.
module tb_signed_mult_arbiter;

    localparam int W     = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [W-1:0]     req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [2*W-1:0]   rsp_p;
    logic             rsp_id;
    logic [CNT_W-1:0] grant_cnt0, grant_cnt1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    signed_mult_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_p      (rsp_p),
        .rsp_id     (rsp_id),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] smul(input logic [3:0] a, input logic [3:0] b);
        int x, y, p;
        x = $signed(a);
        y = $signed(b);
        p = x * y;
        return p[7:0];
    endfunction

    function automatic int cnt_exp(input int n);
`ifdef SIGNED_MULT_ARB_STATS_EN
        return n % (1 << CNT_W);
`else
        return 0 * n;
`endif
    endfunction

    // Transaction-level model: at most one operation in flight; result is
    // visible from the second cycle after acceptance until taken.
    bit         m_inf  = 1'b0;
    int         m_age  = 0;
    logic [7:0] m_p    = '0;
    bit         m_id   = 1'b0;
    bit         m_last = 1'b1;
    int         m_cnt0 = 0, m_cnt1 = 0;

    function automatic bit pick(input bit v0, input bit v1, input bit last);
        if (v0 && v1) return !last;
        if (v1) return 1'b1;
        return 1'b0;
    endfunction

    // Compare on the falling edge, advance the model on the rising edge
    always begin : model_cmp
        bit exp_rv, any, w;
        @(negedge clk);
        if (!rst) begin
            exp_rv = m_inf && (m_age >= 1);
            any    = req0_valid || req1_valid;
            w      = pick(req0_valid, req1_valid, m_last);
            chk("m rsp_valid", rsp_valid, exp_rv);
            chk("m req0_ready", req0_ready, !m_inf && any && !w);
            chk("m req1_ready", req1_ready, !m_inf && any && w);
            if (exp_rv) begin
                chk("m rsp_p", rsp_p, m_p);
                chk("m rsp_id", rsp_id, m_id);
            end
            chk("m grant_cnt0", grant_cnt0, cnt_exp(m_cnt0));
            chk("m grant_cnt1", grant_cnt1, cnt_exp(m_cnt1));
        end
        @(posedge clk);
        if (rst) begin
            m_inf = 0; m_age = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
        end else if (m_inf) begin
            if (m_age >= 1 && rsp_ready) m_inf = 0;
            else m_age++;
        end else if (req0_valid || req1_valid) begin
            w      = pick(req0_valid, req1_valid, m_last);
            m_inf  = 1;
            m_age  = 0;
            m_p    = w ? smul(req1_a, req1_b) : smul(req0_a, req0_b);
            m_id   = w;
            m_last = w;
            if (w) m_cnt1++; else m_cnt0++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one request on requester 0, check latency and literal product
    task automatic do_single(input logic [3:0] a, input logic [3:0] b,
                             input logic [7:0] ep, input string nm);
        int k;
        bit ok;
        req0_valid = 1; req0_a = a; req0_b = b; rsp_ready = 0; ok = 0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req0_ready) begin ok = 1; break; end
            step();
        end
        if (!ok) chk({nm, " accept timeout"}, 0, 1);
        step();
        req0_valid = 0; req0_a = 4'($urandom); req0_b = 4'($urandom);
        ok = 0;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1; break; end
        end
        if (!ok) chk({nm, " rsp timeout"}, 0, 1);
        chk({nm, " latency"}, k, 2);
        chk({nm, " rsp_p"}, rsp_p, ep);
        chk({nm, " rsp_id"}, rsp_id, 0);
        rsp_ready = 1;
        step();
        rsp_ready = 0;
    endtask

    initial begin : main
        int k;
        bit ok;
        logic [7:0] p0;
        logic [3:0] seq;
        int n;

        rst = 1;
        repeat (3) step();
        @(negedge clk);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset req0_ready", req0_ready, 0);
        chk("reset req1_ready", req1_ready, 0);
        chk("reset rsp_p", rsp_p, 0);
        chk("reset rsp_id", rsp_id, 0);
        chk("reset cnt0", grant_cnt0, 0);
        chk("reset cnt1", grant_cnt1, 0);
        step();
        rst = 0;
        step();

        do_single(4'b0001, 4'b0000, 8'h00, "zero");
        do_single(4'b1001, 4'b1111, 8'h07, "m7xm1");
        do_single(4'b1000, 4'b1000, 8'h40, "m8xm8");
        do_single(4'b0111, 4'b1000, 8'hC8, "p7xm8");

        // Backpressure: hold the result while the other requester waits
        req0_valid = 1; req0_a = 4'd3; req0_b = 4'b1110;
        ok = 0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req0_ready) begin ok = 1; break; end
            step();
        end
        if (!ok) chk("bp accept timeout", 0, 1);
        step();
        req0_valid = 0;
        ok = 0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1; break; end
        end
        if (!ok) chk("bp rsp timeout", 0, 1);
        p0 = rsp_p;
        chk("bp rsp_p", p0, 8'hFA);
        step();
        req1_valid = 1; req1_a = 4'($urandom); req1_b = 4'($urandom);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp hold valid", rsp_valid, 1);
            chk("bp hold p", rsp_p, p0);
            chk("bp hold id", rsp_id, 0);
            chk("bp ready0", req0_ready, 0);
            chk("bp ready1", req1_ready, 0);
            step();
        end
        @(negedge clk);
        rsp_ready = 1;
        step();
        rsp_ready = 0; req1_valid = 0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        chk("bp single response", n, 0);
        chk("stats cnt0 after 5", grant_cnt0, cnt_exp(5));
        chk("stats cnt1 after 5", grant_cnt1, 0);

        // Reset while in MUL: response dropped, next tie goes to requester 0
        step();
        req0_valid = 1; req0_a = 4'd5; req0_b = 4'd5;
        ok = 0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req0_ready) begin ok = 1; break; end
            step();
        end
        if (!ok) chk("rst accept timeout", 0, 1);
        step();
        req0_valid = 0;
        rst = 1;
        step();
        rst = 0;
        req0_valid = 1; req1_valid = 1; rsp_ready = 1;
        seq = '0; n = 0;
        for (k = 0; k < 40 && n < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("rst mid rsp_valid", rsp_valid, 0);
                chk("rst mid rsp_p", rsp_p, 0);
                chk("rst tie ready0", req0_ready, 1);
                chk("rst tie ready1", req1_ready, 0);
            end
            if (req0_ready) begin seq[n] = 1'b0; n++; end
            else if (req1_ready) begin seq[n] = 1'b1; n++; end
            step();
            req0_a = 4'($urandom); req0_b = 4'($urandom);
            req1_a = 4'($urandom); req1_b = 4'($urandom);
        end
        chk("rr grant count", n, 4);
        chk("rr sequence", seq, 4'b1010);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step();
            req0_valid = 1'($urandom);
            req1_valid = 1'($urandom);
            req0_a = 4'($urandom); req0_b = 4'($urandom);
            req1_a = 4'($urandom); req1_b = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
        end
        step();
        rst = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
